// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// The slave modport is the arbiter's view of the bus. The master modport is the view of the requesters and memory.
interface mem_arbiter_if;
    logic       req0, req1;
    logic       lock0, lock1;
    logic       wen0, wen1;
    logic [7:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1;
    logic       rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       mem_wen;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    modport slave (
        input  req0, req1, lock0, lock1, wen0, wen1,
        input  addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_wen, mem_address, mem_data_in
    );

    modport master (
        output req0, req1, lock0, lock1, wen0, wen1,
        output addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_wen, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock that shares a single-port memory between two requesters.
// Read returns are tagged with the issuing port and delayed by the memory latency.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state, state_nxt;
    logic               last;
    logic               gnt0, gnt1;
    logic               push_vld;
    logic [MEM_LAT-1:0] vld_p;
    logic [MEM_LAT-1:0] port_p;

    // Grants are forced low while reset is held, whatever the requests are.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
                end
                OWN0: begin
                    if (bus.req0) gnt0 = 1'b1;
                    else          state_nxt = IDLE;
                end
                OWN1: begin
                    if (bus.req1) gnt1 = 1'b1;
                    else          state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
            if (gnt0)      state_nxt = bus.lock0 ? OWN0 : IDLE;
            else if (gnt1) state_nxt = bus.lock1 ? OWN1 : IDLE;
        end
    end

    always_comb begin
        bus.mem_wen     = 1'b0;
        bus.mem_address = 8'h00;
        bus.mem_data_in = 8'h00;
        if (gnt0) begin
            bus.mem_wen     = bus.wen0;
            bus.mem_address = bus.addr0;
            bus.mem_data_in = bus.wdata0;
        end else if (gnt1) begin
            bus.mem_wen     = bus.wen1;
            bus.mem_address = bus.addr1;
            bus.mem_data_in = bus.wdata1;
        end
    end

    assign push_vld = (gnt0 && !bus.wen0) || (gnt1 && !bus.wen1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (gnt0)      last <= 1'b0;
            else if (gnt1) last <= 1'b1;
        end
    end

    // Return pipeline: stage p0 holds the issue cycle, and the last stage lines up with memory data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p  <= '0;
            port_p <= '0;
        end else begin
            vld_p[0]  <= push_vld;
            port_p[0] <= gnt1;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                port_p[i] <= port_p[i-1];
            end
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rst && vld_p[MEM_LAT-1] && !port_p[MEM_LAT-1];
    assign bus.rvalid1 = rst && vld_p[MEM_LAT-1] &&  port_p[MEM_LAT-1];
    assign bus.rdata   = bus.mem_data_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus a hand-written reset-during-read sequence.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if bus();
    mem_arbiter #(.MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory model: the write commits at the edge that ends the grant cycle, and read data appears LAT cycles later.
    logic [7:0] mem [256];
    logic [7:0] dq  [LAT];
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_address] <= bus.mem_data_in;
        dq[0] <= mem[bus.mem_address];
        for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
    end
    assign bus.mem_data_out = dq[LAT-1];

    typedef struct {
        logic r0, l0, w0; logic [7:0] a0, d0;
        logic r1, l1, w1; logic [7:0] a1, d1;
        logic g0, g1, v0, v1; logic [7:0] erd;
        logic emw; logic [7:0] ema, emd;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(
        input logic r0, l0, w0, input logic [7:0] a0, d0,
        input logic r1, l1, w1, input logic [7:0] a1, d1,
        input logic g0, g1, v0, v1, input logic [7:0] erd,
        input logic emw, input logic [7:0] ema, emd);
        vec_t v;
        v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.erd = erd;
        v.emw = emw; v.ema = ema; v.emd = emd;
        return v;
    endfunction

    task automatic drive(input logic r0, l0, w0, input logic [7:0] a0, d0,
                         input logic r1, l1, w1, input logic [7:0] a1, d1);
        bus.req0 = r0; bus.lock0 = l0; bus.wen0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.lock1 = l1; bus.wen1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt0"},    8'(bus.gnt0),    8'h00);
        chk({tag, ".gnt1"},    8'(bus.gnt1),    8'h00);
        chk({tag, ".rvalid0"}, 8'(bus.rvalid0), 8'h00);
        chk({tag, ".rvalid1"}, 8'(bus.rvalid1), 8'h00);
        chk({tag, ".mem_wen"}, 8'(bus.mem_wen), 8'h00);
        chk({tag, ".mem_addr"}, bus.mem_address, 8'h00);
        chk({tag, ".mem_din"},  bus.mem_data_in, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

        // Contention from reset, single-port write/read, locked writes, and lock release on idle.
        vecs[0]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 1,0,0,0,8'h00, 0,8'h01,8'h00);
        vecs[1]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 0,1,0,0,8'h00, 0,8'h81,8'h00);
        vecs[2]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 1,0,1,0,8'h5B, 0,8'h01,8'h00);
        vecs[3]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 0,1,0,1,8'hDB, 0,8'h81,8'h00);
        vecs[4]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 1,0,1,0,8'h5B, 0,8'h01,8'h00);
        vecs[5]  = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h81,8'h00, 0,1,0,1,8'hDB, 0,8'h81,8'h00);
        vecs[6]  = mk(1,0,1,8'h20,8'hA5, 0,0,0,8'h00,8'h00, 1,0,1,0,8'h5B, 1,8'h20,8'hA5);
        vecs[7]  = mk(1,0,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,8'hDB, 0,8'h20,8'h00);
        vecs[8]  = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 0,8'h00,8'h00);
        vecs[9]  = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'hA5, 0,8'h00,8'h00);
        vecs[10] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 0,8'h00,8'h00);
        vecs[11] = mk(1,0,0,8'h30,8'h00, 1,1,1,8'h00,8'h11, 0,1,0,0,8'h00, 1,8'h00,8'h11);
        vecs[12] = mk(1,0,0,8'h30,8'h00, 1,1,1,8'h01,8'h12, 0,1,0,0,8'h00, 1,8'h01,8'h12);
        vecs[13] = mk(1,0,0,8'h30,8'h00, 1,1,1,8'h02,8'h13, 0,1,0,0,8'h00, 1,8'h02,8'h13);
        vecs[14] = mk(1,0,0,8'h30,8'h00, 1,1,1,8'h03,8'h14, 0,1,0,0,8'h00, 1,8'h03,8'h14);
        vecs[15] = mk(1,0,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 0,8'h00,8'h00);
        vecs[16] = mk(1,0,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00, 0,8'h30,8'h00);
        vecs[17] = mk(0,0,0,8'h00,8'h00, 1,0,0,8'h02,8'h00, 0,1,0,0,8'h00, 0,8'h02,8'h00);
        vecs[18] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'h6A, 0,8'h00,8'h00);
        vecs[19] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'h13, 0,8'h00,8'h00);
        vecs[20] = mk(1,1,0,8'h03,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00, 0,8'h03,8'h00);
        vecs[21] = mk(0,0,0,8'h00,8'h00, 1,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 0,8'h00,8'h00);
        vecs[22] = mk(0,0,0,8'h00,8'h00, 1,0,0,8'h00,8'h00, 0,1,1,0,8'h14, 0,8'h00,8'h00);
        vecs[23] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 0,8'h00,8'h00);
        vecs[24] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'h11, 0,8'h00,8'h00);

        // Reset held with live requests: every output must stay at zero.
        drive(1,1,1,8'h55,8'hFF, 1,1,1,8'hAA,8'hEE);
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(vecs[i].r0, vecs[i].l0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].l1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d.gnt0", i),    8'(bus.gnt0),    8'(vecs[i].g0));
            chk($sformatf("v%0d.gnt1", i),    8'(bus.gnt1),    8'(vecs[i].g1));
            chk($sformatf("v%0d.rvalid0", i), 8'(bus.rvalid0), 8'(vecs[i].v0));
            chk($sformatf("v%0d.rvalid1", i), 8'(bus.rvalid1), 8'(vecs[i].v1));
            chk($sformatf("v%0d.mem_wen", i), 8'(bus.mem_wen), 8'(vecs[i].emw));
            chk($sformatf("v%0d.mem_addr", i), bus.mem_address, vecs[i].ema);
            chk($sformatf("v%0d.mem_din", i),  bus.mem_data_in, vecs[i].emd);
            if (vecs[i].v0 || vecs[i].v1)
                chk($sformatf("v%0d.rdata", i), bus.rdata, vecs[i].erd);
        end

        // Reset pulse while a read is in flight: the read is discarded and last returns to 1.
        @(negedge clk);
        drive(1,0,0,8'h10,8'h00, 0,0,0,8'h00,8'h00);
        #1 chk("rmr.t.gnt0", 8'(bus.gnt0), 8'h01);
        @(negedge clk);
        rst = 1'b0;
        drive(1,1,1,8'h55,8'hFF, 1,1,1,8'hAA,8'hEE);
        #1 chk_zero("rmr.t1");
        @(negedge clk);
        rst = 1'b1;
        drive(1,0,0,8'h10,8'h00, 1,0,0,8'h11,8'h00);
        #1;
        chk("rmr.t2.rvalid0", 8'(bus.rvalid0), 8'h00);
        chk("rmr.t2.rvalid1", 8'(bus.rvalid1), 8'h00);
        chk("rmr.t2.gnt0",    8'(bus.gnt0),    8'h01);
        chk("rmr.t2.gnt1",    8'(bus.gnt1),    8'h00);
        @(negedge clk);
        #1;
        chk("rmr.t3.gnt1",    8'(bus.gnt1),    8'h01);
        chk("rmr.t3.gnt0",    8'(bus.gnt0),    8'h00);
        chk("rmr.t3.rvalid0", 8'(bus.rvalid0), 8'h00);
        @(negedge clk);
        drive(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
        #1;
        chk("rmr.t4.rvalid0", 8'(bus.rvalid0), 8'h01);
        chk("rmr.t4.rdata",   bus.rdata,       8'h4A);
        @(negedge clk);
        #1;
        chk("rmr.t5.rvalid1", 8'(bus.rvalid1), 8'h01);
        chk("rmr.t5.rvalid0", 8'(bus.rvalid0), 8'h00);
        chk("rmr.t5.rdata",   bus.rdata,       8'h4B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 8-bit `memory` between the `cpu` (port 0) and a loader/debug requester (port 1). It grants at most one access per cycle, using round-robin on contention. A granted port may hold a lock for back-to-back exclusive access. Read data returns with a fixed, parameterised latency, tagged to the issuing port. It sits between the requesters and `memory`, replacing the direct cpu-to-memory connection.

## Interface
- `MEM_LAT`, 1, read latency of `memory` in cycles (legal 1..3); memory `data_out` is valid `MEM_LAT` cycles after the address is presented.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: access request; must hold with fields stable until granted.
- `lock0`, `lock1` in 1: sampled with an accepted request; keeps exclusive ownership for the next cycle.
- `wen0`, `wen1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in 8: access address.
- `wdata0`, `wdata1` in 8: write data.
- `gnt0`, `gnt1` out 1: combinational; request accepted this cycle.
- `rvalid0`, `rvalid1` out 1: read data for this port is valid this cycle.
- `rdata` out 8: shared read data, passed through from `mem_data_out`; meaningful only when an `rvalid` is high.
- `mem_wen` out 1: memory write enable.
- `mem_address` out 8: memory address.
- `mem_data_in` out 8: memory write data.
- `mem_data_out` in 8: memory read data.

## Operation
- **States:**
  - IDLE: no owner.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- **IDLE arbitration:**
  - If only one port requests, that port is granted.
  - If both request, the port not granted most recently is granted.
  - The `last` register resets to 1, so port 0 wins the first tie.
- **OWNn:**
  - Only port n can be granted; the other port's request waits with `gnt` low.
  - If port n does not request in an OWNn cycle, the lock is released and the FSM returns to IDLE in the next cycle.
- **Transitions on a grant to port n:**
  - With `lockn` = 1, next state is OWNn.
  - With `lockn` = 0, next state is IDLE.
  - `last` <= n.
- **Memory drive:**
  - In a grant cycle, the granted port's `wen`/`addr`/`wdata` drive `mem_wen`/`mem_address`/`mem_data_in` combinationally.
  - With no grant: `mem_wen` = 0, `mem_address` = 0, `mem_data_in` = 0.
- **Read return:**
  - Each granted read pushes {valid, port} into a `MEM_LAT`-deep shift pipeline.
  - `rvalidn` is high exactly `MEM_LAT` cycles after the grant cycle.
  - Writes push valid = 0.
  - One entry per cycle, so there are never return collisions.
- **Ordering:** back-to-back grants are allowed every cycle; there are no bubbles and no limit on outstanding reads beyond the pipeline depth.

## Timing
- **Reset (async assert, `rst` = 0):**
  - FSM = IDLE, `last` = 1, return pipeline cleared.
  - `gnt0`/`gnt1`/`rvalid0`/`rvalid1`/`mem_wen` = 0, `mem_address` = 0, `mem_data_in` = 0, independent of inputs.
  - Reads in flight are discarded, with no `rvalid` after release.
- **Reset release:** synchronous to the first rising edge; grants are possible in the first cycle with `rst` = 1.
- **Grant:** same-cycle (zero latency). The requester sees `gnt` and may change fields after that rising edge.
- **Write:** committed by `memory` at the rising edge ending the grant cycle.
- **Read:** grant at cycle t gives `rvalid` and valid `rdata` at cycle t+`MEM_LAT`.
- **Read-after-write, same address in consecutive grants:** returns the new data, which follows from the memory write-then-read ordering.
- **Simultaneous `req0`/`req1` while OWN1:** `gnt1` only; `gnt0` stays low until IDLE is reached and arbitration occurs.
- **Starvation bound:** an unlocked contending port waits at most 1 cycle; behind a lock, it waits for the lock duration.

## Test plan
- **Reset mid-read:**
  - Stimulus: `MEM_LAT` = 2; port 0 reads `addr` 0x10 at cycle t; `rst` pulses low at t+1.
  - Response: no `rvalid0` at t+2; all outputs 0 during reset.
- **Single port write/read:**
  - Stimulus: port 0 writes 0xA5 to 0x20, then reads 0x20.
  - Response: `gnt0` in both cycles; `rvalid0` with `rdata` = 0xA5 exactly `MEM_LAT` cycles after the read grant; `rvalid1` stays 0.
- **Contention round-robin:**
  - Stimulus: both ports hold read requests continuously for 6 cycles from reset.
  - Response: grant sequence 0,1,0,1,0,1; `rvalid` tags match the same sequence delayed by `MEM_LAT`.
- **Lock:**
  - Stimulus: port 1 issues 4 locked writes (0x00..0x03 <= 0x11..0x14) while `req0` is held high.
  - Response: `gnt0` = 0 for those 4 cycles; `gnt0` = 1 on the cycle after port 1 drops `req1`.
- **Lock release on idle:**
  - Stimulus: port 0 locked grant, then `req0` = 0 for one cycle while `req1` = 1.
  - Response: no grant in the release cycle; `gnt1` in the following cycle.
- **CPU integration:**
  - Stimulus: `cpu` on port 0 runs a program from `memory`, with port 1 idle.
  - Response: reaches `halt` with the same final memory contents as the direct connection.
